// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response port between if_fetch_unit and memory.
// master: fetch side, slave: memory side.
interface if_fetch_unit_if;
    logic        Mem_ReqValid;
    logic [31:0] Mem_ReqAddr;
    logic        Mem_ReqReady;
    logic        Mem_RspValid;
    logic [31:0] Mem_RspData;

    modport master (
        output Mem_ReqValid,
        output Mem_ReqAddr,
        input  Mem_ReqReady,
        input  Mem_RspValid,
        input  Mem_RspData
    );

    modport slave (
        input  Mem_ReqValid,
        input  Mem_ReqAddr,
        output Mem_ReqReady,
        output Mem_RspValid,
        output Mem_RspData
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage with an in-order prefetch queue feeding ID.
// Define IF_BUBBLE_COUNT_EN to add the saturating Out_BubbleCount port.
module if_fetch_unit #(
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic            Clk,
    input  logic            Rst,
    if_fetch_unit_if.master mem,
    input  logic            Redirect,
    input  logic [31:0]     Redirect_PC,
    input  logic            Stall,
    output logic            Out_Valid,
    output logic [31:0]     Out_PC,
    output logic [31:0]     Out_Instr
`ifdef IF_BUBBLE_COUNT_EN
    ,
    output logic [31:0]     Out_BubbleCount
`endif
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH = QUEUE_DEPTH[CW:0];

    logic [31:0]   fpc_q, fpc_d;
    logic [31:0]   rpc_q, rpc_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_q, drop_d;
    logic          out_valid_q, out_valid_d;
    logic [31:0]   out_pc_q, out_pc_d;
    logic [31:0]   out_instr_q, out_instr_d;

    logic [31:0]   q_instr_mem [QUEUE_DEPTH];
    logic [31:0]   q_pc_mem    [QUEUE_DEPTH];

    logic [CW:0]   inflight;
    logic [CW-1:0] acc_inc;
    logic [CW-1:0] rsp_dec;
    logic          req_valid;
    logic          accept;
    logic          rsp;
    logic          push;
    logic          pop;

    // A slot is reserved for every in-flight response, so pushes never overflow.
    always_comb begin
        inflight  = {1'b0, count_q} + {1'b0, outstanding_q};
        req_valid = !Rst && !Redirect && (inflight < DEPTH);
        accept    = req_valid && mem.Mem_ReqReady;
        rsp       = mem.Mem_RspValid;
        push      = rsp && (drop_q == '0) && !Redirect;
        pop       = !Redirect && !Stall && (count_q != '0);
        acc_inc   = {{(CW-1){1'b0}}, accept};
        rsp_dec   = {{(CW-1){1'b0}}, rsp};
    end

    always_comb begin
        fpc_d         = fpc_q;
        rpc_d         = rpc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        drop_d        = drop_q;
        outstanding_d = outstanding_q + acc_inc - rsp_dec;
        if (Redirect) begin
            fpc_d    = Redirect_PC;
            rpc_d    = Redirect_PC;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            // Everything still in flight belongs to the old path.
            drop_d   = outstanding_q - rsp_dec;
        end else begin
            if (accept) begin
                fpc_d = fpc_q + 32'd4;
            end
            if (rsp && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
            if (push) begin
                rpc_d    = rpc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_instr_d = out_instr_q;
        if (Redirect) begin
            out_valid_d = 1'b0;
            out_pc_d    = '0;
            out_instr_d = '0;
        end else if (Stall) begin
            out_valid_d = out_valid_q;
        end else if (count_q != '0) begin
            out_valid_d = 1'b1;
            out_pc_d    = q_pc_mem[rd_ptr_q];
            out_instr_d = q_instr_mem[rd_ptr_q];
        end else begin
            out_valid_d = 1'b0;
            out_instr_d = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            fpc_q         <= RESET_PC;
            rpc_q         <= RESET_PC;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
            out_valid_q   <= 1'b0;
            out_pc_q      <= '0;
            out_instr_q   <= '0;
        end else begin
            fpc_q         <= fpc_d;
            rpc_q         <= rpc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            out_valid_q   <= out_valid_d;
            out_pc_q      <= out_pc_d;
            out_instr_q   <= out_instr_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            q_instr_mem[wr_ptr_q] <= mem.Mem_RspData;
            q_pc_mem[wr_ptr_q]    <= rpc_q + 32'd4;
        end
    end

`ifdef IF_BUBBLE_COUNT_EN
    logic        bubble;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        bubble       = !Redirect && !Stall && (count_q == '0);
        bubble_cnt_d = bubble_cnt_q;
        if (bubble && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign Out_BubbleCount = bubble_cnt_q;
`endif

    assign mem.Mem_ReqValid = req_valid;
    assign mem.Mem_ReqAddr  = fpc_q;
    assign Out_Valid        = out_valid_q;
    assign Out_PC           = out_pc_q;
    assign Out_Instr        = out_instr_q;
endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction fetch stage with a small prefetch queue. It drives a request/response instruction-memory port, buffers returned words in order, and hands one instruction per cycle to the ID stage through registered outputs named as ID consumes them (Out_PC, Out_Instr). It accepts branch/jump redirects and hazard stalls from ID. It replaces the bare PC-register fetch in front of ID and sits directly upstream of it.

## Interface

Reset is synchronous and active-high on the single clock `Clk`; reset port is `Rst`.

Parameters:
- `QUEUE_DEPTH`, default 4: prefetch queue entries; power of two, at least 2.
- `RESET_PC`, default 32'h0000_0000: fetch address after reset.

Ports:
- `Clk`  in  1  clock; all state updates on rising edge.
- `Rst`  in  1  synchronous, active-high reset.
- `Mem_ReqValid`  out  1  fetch request valid.
- `Mem_ReqAddr`  out  32  fetch address; always equals the fetch PC register.
- `Mem_ReqReady`  in  1  memory accepts the request this cycle.
- `Mem_RspValid`  in  1  instruction word returned; in order; no backpressure.
- `Mem_RspData`  in  32  returned instruction word.
- `Redirect`  in  1  branch/jump taken in ID (Out_PCSrc/Out_Jump).
- `Redirect_PC`  in  32  target address (Out_BranchPC/Out_JumpPC).
- `Stall`  in  1  ID hazard; hold outputs.
- `Out_Valid`  out  1  Out_Instr holds a real instruction.
- `Out_PC`  out  32  address of Out_Instr plus 4.
- `Out_Instr`  out  32  instruction to ID; 32'h0 (NOP) when not valid.

## Operation

- State:
  - fetch PC `fpc`.
  - Queue of QUEUE_DEPTH entries of {instr, pc+4}, with rd/wr pointers and `count`.
  - `outstanding`: accepted requests not yet responded.
  - `drop`: responses still to discard.
  - Output registers.
  - Counter widths are clog2(QUEUE_DEPTH)+1.
- Request issue:
  - Mem_ReqValid = !Rst && !Redirect && (count + outstanding < QUEUE_DEPTH).
  - This reserves a queue slot for every in-flight response.
- Acceptance: when Mem_ReqValid && Mem_ReqReady, `fpc` advances by 4 (wraps modulo 2^32) and `outstanding` increments.
- Response handling: each Mem_RspValid decrements `outstanding`.
  - If `drop` > 0, the word is discarded and `drop` decrements.
  - Otherwise {Mem_RspData, tag+4} is pushed. The tag is tracked by a response-address register `rpc`, which advances by 4 per kept response.
- Output update, in priority order:
  - Redirect: Out_Valid 0, Out_Instr 0, Out_PC 0.
  - Stall: hold all outputs.
  - count > 0: load head and pop.
  - Otherwise: bubble (Out_Valid 0, Out_Instr 0; Out_PC holds).
- Redirect, taken on the edge, overrides Stall:
  - Queue cleared (count 0, pointers 0).
  - `fpc` and `rpc` load Redirect_PC.
  - `drop` loads outstanding − (Mem_RspValid ? 1 : 0) + drop adjustment. Net effect: every response for a pre-redirect request is discarded.
  - No request is issued in the redirect cycle.
- A queue response never bypasses into the output register; it enters the queue first.
- Simultaneous push and pop: count is unchanged; both pointers advance.
- Full queue: the issue gate guarantees no overflow, so no push is ever lost.

## Timing

- Reset values:
  - Out_Valid 0, Out_Instr 0, Out_PC 0.
  - fpc = rpc = RESET_PC.
  - count, outstanding, drop all 0.
  - Mem_ReqValid 0 while Rst is high.
- Reset mid-operation discards all in-flight state. Memory shares Rst, so no pre-reset responses arrive after reset.
- Latency: request accept at edge N; response at edge N+L (L ≥ 1); queue entry after edge N+L; Out_Instr valid after edge N+L+1 if not stalled.
- With L=1 and Mem_ReqReady constantly high, steady-state throughput is 1 instruction/cycle, starting 3 cycles after reset release.
- Redirect penalty: the first target instruction reaches Out_Instr no earlier than 3 cycles after the redirect edge (L=1).

## Configuration

- `IF_BUBBLE_COUNT_EN`:
  - When defined, adds output port `Out_BubbleCount` (out, 32 bits), reset to 0. It increments, saturating at 32'hFFFF_FFFF, on every edge where the output loads a bubble because of an empty queue, excluding Redirect and Stall cycles.
  - When undefined, the port and counter do not exist, and behaviour is otherwise identical.

## Test plan

- Reset to RESET_PC=0; memory returns word = address, L=1, always ready -> Out_Instr sequence 0,4,8,… with Out_PC 4,8,12,…; Out_Valid high from the 3rd cycle after reset.
- Mem_ReqReady held low for 10 cycles after queue fill -> Out_Instr continues for 4 cycles (depth 4), then bubbles (Out_Instr 0, Out_Valid 0); Mem_ReqValid never asserts with count+outstanding=4.
- Stall high for 5 cycles mid-stream at Out_Instr=0x10 -> outputs hold 0x10/0x14; next instruction after release is 0x14; no instruction lost or duplicated.
- L=3 with 3 outstanding, Redirect to 0x100 -> three stale responses discarded; next valid Out_Instr=0x100, Out_PC=0x104.
- Redirect and Stall asserted together -> redirect wins: outputs become a bubble and fetch restarts at Redirect_PC; Rst asserted mid-stream -> all outputs 0 on the next edge and fetch restarts at RESET_PC.
- With IF_BUBBLE_COUNT_EN, 6 ready-low starvation bubbles -> Out_BubbleCount=6; Stall cycles not counted.
